// File: rtl/reset_sequencer.sv
// Reset generator: synchronises the master reset release, holds every channel for a
// fixed time, then releases the channels in staggered index order. Supports a masked soft reset.
module reset_sequencer #(
  parameter int NUM_CHANNELS   = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    soft_reset_req,
  input  logic [NUM_CHANNELS-1:0] channel_mask,
  output logic [NUM_CHANNELS-1:0] rst_out,
  output logic                    all_released,
  output logic                    busy,
  output logic [7:0]              soft_reset_count
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + (NUM_CHANNELS - 1) * STAGGER_CYCLES + 2);

  typedef enum logic [1:0] {SYNC, HOLD, RELEASE, RUN} state_t;

  state_t                  state, state_next;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic [CNT_W-1:0]        cnt, cnt_next, cnt_inc;
  logic [NUM_CHANNELS-1:0] seq_mask, seq_mask_next;
  logic [NUM_CHANNELS-1:0] rst_next, release_hit;
  logic                    all_released_next;
  logic [7:0]              count_next;
  logic                    advance;

  // The chain is async-set by reset and only ever shifts zeros in, so the release
  // of the master reset reaches the sequencer purely through flops.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= SYNC;
      cnt              <= '0;
      seq_mask         <= '1;
      rst_out          <= '1;
      all_released     <= 1'b0;
      soft_reset_count <= '0;
    end else begin
      state            <= state_next;
      cnt              <= cnt_next;
      seq_mask         <= seq_mask_next;
      rst_out          <= rst_next;
      all_released     <= all_released_next;
      soft_reset_count <= count_next;
    end
  end

  // cnt holds the number of edges since the sequence start edge (the edge that
  // raised the soft reset, or the edge the synchroniser output went low).
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next        = state;
    cnt_next          = cnt;
    seq_mask_next     = seq_mask;
    rst_next          = rst_out;
    all_released_next = all_released;
    count_next        = soft_reset_count;
    release_hit       = '0;
    cnt_inc           = cnt + CNT_W'(1);
    advance           = (state == HOLD) || (state == RELEASE) ||
                        ((state == SYNC) && !sync_q[SYNC_STAGES-1]);

    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (seq_mask[i] && (cnt_inc == CNT_W'(HOLD_CYCLES + i * STAGGER_CYCLES)))
        release_hit[i] = 1'b1;
    end

    case (state)
      SYNC, HOLD, RELEASE: begin
        if (advance) begin
          cnt_next = cnt_inc;
          rst_next = rst_out & ~release_hit;
          if (rst_next == '0) begin
            state_next        = RUN;
            all_released_next = 1'b1;
          end else if ((release_hit != '0) || (state == RELEASE)) begin
            state_next = RELEASE;
          end else begin
            state_next = HOLD;
          end
        end
      end
      RUN: begin
        if (soft_reset_req && (channel_mask != '0)) begin
          state_next        = HOLD;
          cnt_next          = '0;
          seq_mask_next     = channel_mask;
          rst_next          = channel_mask;
          all_released_next = 1'b0;
          if (soft_reset_count != 8'hFF) count_next = soft_reset_count + 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign busy = ~all_released;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-on timing, soft reset, ignored requests,
// async reset mid-sequence, count saturation and a zero-stagger configuration.
`timescale 1ns/1ps
module tb_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       soft_reset_req = 1'b0;
  logic [3:0] channel_mask = 4'b0000;
  logic [3:0] rst_out;
  logic       all_released;
  logic       busy;
  logic [7:0] soft_reset_count;

  logic       reset6 = 1'b1;
  logic       soft_reset_req6 = 1'b0;
  logic [7:0] channel_mask6 = 8'h00;
  logic [7:0] rst_out6;
  logic       all_released6;
  logic       busy6;
  logic [7:0] soft_reset_count6;

  int checks = 0;
  int errors = 0;

  // Hand-computed release edges for the default parameters.
  int po_rel[4]   = '{18, 22, 26, 30};
  int soft_rel[4] = '{16, 20, 24, 28};

  always #5 clock = ~clock;

  reset_sequencer dut (
    .clock            (clock),
    .reset            (reset),
    .soft_reset_req   (soft_reset_req),
    .channel_mask     (channel_mask),
    .rst_out          (rst_out),
    .all_released     (all_released),
    .busy             (busy),
    .soft_reset_count (soft_reset_count)
  );

  reset_sequencer #(
    .NUM_CHANNELS   (8),
    .SYNC_STAGES    (3),
    .HOLD_CYCLES    (3),
    .STAGGER_CYCLES (0)
  ) dut6 (
    .clock            (clock),
    .reset            (reset6),
    .soft_reset_req   (soft_reset_req6),
    .channel_mask     (channel_mask6),
    .rst_out          (rst_out6),
    .all_released     (all_released6),
    .busy             (busy6),
    .soft_reset_count (soft_reset_count6)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Power-on sequence up to stop_edge; optionally pulses an all-ones request at req_edge.
  task automatic power_on(input int stop_edge, input int req_edge);
    logic [5:0] exp_v;
    reset = 1'b1;
    soft_reset_req = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({rst_out, all_released, busy, soft_reset_count} !== {4'b1111, 1'b0, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL reset_state: got rst=%b rel=%b busy=%b cnt=%0d, want rst=1111 rel=0 busy=1 cnt=0",
               rst_out, all_released, busy, soft_reset_count);
    end
    reset = 1'b0;
    for (int e = 1; e <= stop_edge; e++) begin
      if (e == req_edge) begin
        soft_reset_req = 1'b1;
        channel_mask   = 4'b1111;
      end
      tick();
      soft_reset_req = 1'b0;
      for (int i = 0; i < 4; i++) exp_v[5-i-2+0] = 1'b0;
      for (int i = 0; i < 4; i++) exp_v[2+i] = (e < po_rel[i]);
      exp_v[1] = (e >= 30);
      exp_v[0] = (e < 30);
      checks++;
      if ({rst_out, all_released, busy} !== exp_v) begin
        errors++;
        $display("FAIL power_on edge %0d: got {rst,rel,busy}=%b, want %b", e,
                 {rst_out, all_released, busy}, exp_v);
      end
    end
    checks++;
    if (soft_reset_count !== 8'd0) begin
      errors++;
      $display("FAIL power_on_count: got %0d, want 0", soft_reset_count);
    end
  endtask

  // Soft reset of mask from RUN, followed for stop_k edges; optional ignored request at req_k.
  task automatic soft_seq(input logic [3:0] mask, input int stop_k, input int req_k,
                          input int exp_count);
    logic [5:0] exp_v;
    int last;
    last = 0;
    for (int i = 0; i < 4; i++) if (mask[i]) last = soft_rel[i];
    checks++;
    if (all_released !== 1'b1) begin
      errors++;
      $display("FAIL soft_precondition: got all_released=%b, want 1", all_released);
    end
    soft_reset_req = 1'b1;
    channel_mask   = mask;
    tick();
    soft_reset_req = 1'b0;
    checks++;
    if ({rst_out, all_released, busy, soft_reset_count} !== {mask, 1'b0, 1'b1, 8'(exp_count)}) begin
      errors++;
      $display("FAIL soft_accept: got rst=%b rel=%b busy=%b cnt=%0d, want rst=%b rel=0 busy=1 cnt=%0d",
               rst_out, all_released, busy, soft_reset_count, mask, exp_count);
    end
    for (int k = 1; k <= stop_k; k++) begin
      if (k == req_k) begin
        soft_reset_req = 1'b1;
        channel_mask   = 4'b1111;
      end
      tick();
      soft_reset_req = 1'b0;
      for (int i = 0; i < 4; i++) exp_v[2+i] = mask[i] && (k < soft_rel[i]);
      exp_v[1] = (k >= last);
      exp_v[0] = (k < last);
      checks++;
      if ({rst_out, all_released, busy, soft_reset_count} !== {exp_v, 8'(exp_count)}) begin
        errors++;
        $display("FAIL soft_seq k=%0d: got {rst,rel,busy}=%b cnt=%0d, want %b cnt=%0d", k,
                 {rst_out, all_released, busy}, soft_reset_count, exp_v, exp_count);
      end
    end
  endtask

  task automatic test_reset();
    power_on(30, 0);
  endtask

  task automatic test_soft_reset();
    soft_seq(4'b0101, 24, 0, 1);
  endtask

  task automatic test_ignored();
    power_on(30, 10);
    power_on(30, 30);
    tick();
    checks++;
    if ({rst_out, all_released, soft_reset_count} !== {4'b0000, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL ignore_final_po: got rst=%b rel=%b cnt=%0d, want rst=0000 rel=1 cnt=0",
               rst_out, all_released, soft_reset_count);
    end
    soft_seq(4'b0101, 24, 10, 1);
    soft_seq(4'b0001, 16, 16, 2);
    tick();
    checks++;
    if ({rst_out, all_released, soft_reset_count} !== {4'b0000, 1'b1, 8'd2}) begin
      errors++;
      $display("FAIL ignore_final_soft: got rst=%b rel=%b cnt=%0d, want rst=0000 rel=1 cnt=2",
               rst_out, all_released, soft_reset_count);
    end
    soft_reset_req = 1'b1;
    channel_mask   = 4'b0000;
    tick();
    soft_reset_req = 1'b0;
    tick();
    checks++;
    if ({rst_out, all_released, soft_reset_count} !== {4'b0000, 1'b1, 8'd2}) begin
      errors++;
      $display("FAIL ignore_mask0: got rst=%b rel=%b cnt=%0d, want rst=0000 rel=1 cnt=2",
               rst_out, all_released, soft_reset_count);
    end
  endtask

  task automatic test_async_reset();
    power_on(22, 0);
    reset = 1'b1;
    #1;
    checks++;
    if ({rst_out, all_released, soft_reset_count} !== {4'b1111, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL async_po: got rst=%b rel=%b cnt=%0d, want rst=1111 rel=0 cnt=0",
               rst_out, all_released, soft_reset_count);
    end
    power_on(30, 0);
    soft_seq(4'b0010, 20, 0, 1);
    soft_seq(4'b0101, 10, 0, 2);
    reset = 1'b1;
    #1;
    checks++;
    if ({rst_out, all_released, soft_reset_count} !== {4'b1111, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL async_soft: got rst=%b rel=%b cnt=%0d, want rst=1111 rel=0 cnt=0",
               rst_out, all_released, soft_reset_count);
    end
    power_on(30, 0);
  endtask

  task automatic test_back_to_back();
    int w;
    for (int n = 1; n <= 260; n++) begin
      soft_reset_req = 1'b1;
      channel_mask   = 4'b1000;
      tick();
      soft_reset_req = 1'b0;
      checks++;
      if ({rst_out, soft_reset_count} !== {4'b1000, 8'((n > 255) ? 255 : n)}) begin
        errors++;
        $display("FAIL saturate n=%0d: got rst=%b cnt=%0d, want rst=1000 cnt=%0d", n,
                 rst_out, soft_reset_count, (n > 255) ? 255 : n);
      end
      w = 0;
      while (!all_released && w < 40) begin
        tick();
        w++;
      end
      checks++;
      if (w !== 28) begin
        errors++;
        $display("FAIL b2b_release n=%0d: released after %0d edges, want 28", n, w);
      end
    end
  endtask

  task automatic test_params();
    reset6 = 1'b1;
    @(negedge clock);
    checks++;
    if ({rst_out6, all_released6, soft_reset_count6} !== {8'hFF, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL p8_reset: got rst=%b rel=%b cnt=%0d, want rst=11111111 rel=0 cnt=0",
               rst_out6, all_released6, soft_reset_count6);
    end
    reset6 = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if ({rst_out6, all_released6, busy6} !== {((e < 6) ? 8'hFF : 8'h00), (e >= 6), (e < 6)}) begin
        errors++;
        $display("FAIL p8 edge %0d: got rst=%b rel=%b busy=%b, want rst=%b rel=%b", e,
                 rst_out6, all_released6, busy6, (e < 6) ? 8'hFF : 8'h00, (e >= 6));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_soft_reset();
    test_ignored();
    test_async_reset();
    test_back_to_back();
    test_params();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
